// File: rtl/bsg_mem_1r1w_synth.sv
// rtl/bsg_mem_1r1w_synth.sv - synthesized 1-read 1-write register-file memory
module bsg_mem_1r1w_synth #(
  parameter int width_p                = 16,
  parameter int els_p                  = 2,
  parameter int read_write_same_addr_p = 0,
  parameter int harden_p               = 0,
  localparam int addr_width_lp         = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                     w_clk_i,
  input  logic                     w_reset_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic                     r_v_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o
);

  // No hardened macro exists for this memory; refuse to elaborate rather
  // than silently substitute flops for a requested macro.
  if (harden_p != 0) begin : g_no_hard_macro
    $error("bsg_mem_1r1w_synth: harden_p=%0d has no hardened implementation", harden_p);
  end

  logic [width_p-1:0] mem [els_p];

  // Write port: contents are not reset, only overwritten.
  always_ff @(posedge w_clk_i) begin
    if (w_v_i) mem[w_addr_i] <= w_data_i;
  end

  // Read port is asynchronous so the head is visible in the same cycle.
  assign r_data_o = mem[r_addr_i];

  // Catch a caller that reads and writes one slot together when the
  // instance was built without write-through support.
  always_ff @(posedge w_clk_i) begin
    if (!w_reset_i && read_write_same_addr_p == 0 && w_v_i && r_v_i)
      assert (w_addr_i != r_addr_i);
  end

endmodule

// File: rtl/bsg_two_fifo_1r1w_ctrl.sv
// rtl/bsg_two_fifo_1r1w_ctrl.sv - two-entry ready/valid-in, valid/yumi-out FIFO
module bsg_two_fifo_1r1w_ctrl #(
  parameter int width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic wptr_r, rptr_r;
  logic full_r, empty_r;
  logic enq, deq;

  assign ready_o = ~full_r;
  assign v_o     = ~empty_r;
  assign enq     = v_i & ~full_r;
  // A yumi on an empty FIFO is a protocol error; it is flagged by an
  // assertion below but deliberately not masked here.
  assign deq     = yumi_i;

  bsg_mem_1r1w_synth #(
    .width_p               (width_p),
    .els_p                 (2),
    .read_write_same_addr_p(0),
    .harden_p              (0)
  ) mem (
    .w_clk_i  (clk_i),
    .w_reset_i(reset_i),
    .w_v_i    (enq),
    .w_addr_i (wptr_r),
    .w_data_i (data_i),
    .r_v_i    (~empty_r),
    .r_addr_i (rptr_r),
    .r_data_o (data_o)
  );

  // Pointers toggle on each enqueue/dequeue; 1-bit wrap is implicit.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_r <= 1'b0;
      rptr_r <= 1'b0;
    end else begin
      if (enq) wptr_r <= ~wptr_r;
      if (deq) rptr_r <= ~rptr_r;
    end
  end

  // Full/empty change only on a lone enqueue or lone dequeue; a
  // simultaneous pair keeps occupancy where it is.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else if (enq && !deq) begin
      empty_r <= 1'b0;
      full_r  <= (~wptr_r == rptr_r);
    end else if (deq && !enq) begin
      full_r  <= 1'b0;
      empty_r <= (~rptr_r == wptr_r);
    end
  end

  // Protocol and structural invariants, checked outside reset.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(full_r && empty_r));
      assert (!(yumi_i && empty_r));
      assert (!(enq && !empty_r && (wptr_r == rptr_r)));
    end
  end

endmodule

// File: tb/tb_bsg_two_fifo_1r1w_ctrl.sv
// tb/tb_bsg_two_fifo_1r1w_ctrl.sv - self-checking bench for bsg_two_fifo_1r1w_ctrl
module tb_bsg_two_fifo_1r1w_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset_i = 1'b1;
  logic         v_i = 1'b0;
  logic [W-1:0] data_i = '0;
  logic         ready_o;
  logic         v_o;
  logic [W-1:0] data_o;
  logic         yumi_i = 1'b0;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  bsg_two_fifo_1r1w_ctrl #(.width_p(W)) dut (
    .clk_i  (clk),
    .reset_i(reset_i),
    .v_i    (v_i),
    .data_i (data_i),
    .ready_o(ready_o),
    .v_o    (v_o),
    .data_o (data_o),
    .yumi_i (yumi_i)
  );

  typedef struct {
    logic         rst;
    logic         v;
    logic [W-1:0] d;
    logic         y;
    logic         chk;
    logic         exp_ready;
    logic         exp_v;
    logic [W-1:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic v, input logic [W-1:0] d,
                     input logic y, input logic chk, input logic er,
                     input logic ev, input logic [W-1:0] ed);
    vec_t t;
    t.rst = rst; t.v = v; t.d = d; t.y = y;
    t.chk = chk; t.exp_ready = er; t.exp_v = ev; t.exp_data = ed;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp)
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    else
      passed++;
  endtask

  int q[$];

  initial begin
    // rst v d y chk ready v data (outputs observed while these inputs are applied)
    add(1, 0, 16'h0000, 0, 0, 1, 0, 16'h0000);
    add(1, 0, 16'h0000, 0, 1, 1, 0, 16'h0000);
    add(0, 0, 16'h0000, 0, 1, 1, 0, 16'h0000);
    add(0, 0, 16'h0000, 0, 1, 1, 0, 16'h0000);
    add(0, 1, 16'hA5A5, 0, 1, 1, 0, 16'h0000);
    add(0, 1, 16'h1234, 0, 1, 1, 1, 16'hA5A5);
    add(0, 1, 16'hFFFF, 0, 1, 0, 1, 16'hA5A5);
    add(0, 0, 16'h0000, 1, 1, 0, 1, 16'hA5A5);
    add(0, 0, 16'h0000, 1, 1, 1, 1, 16'h1234);
    add(0, 0, 16'h0000, 0, 1, 1, 0, 16'h0000);
    add(0, 1, 16'h0001, 0, 1, 1, 0, 16'h0000);
    for (int k = 0; k < 8; k++)
      add(0, 1, 16'(k + 2), 1, 1, 1, 1, 16'(k + 1));
    add(0, 1, 16'h1111, 0, 1, 1, 1, 16'h0009);
    add(0, 1, 16'hBEEF, 1, 1, 0, 1, 16'h0009);
    add(0, 0, 16'h0000, 0, 1, 1, 1, 16'h1111);
    add(0, 1, 16'h2222, 0, 1, 1, 1, 16'h1111);
    add(1, 1, 16'h3333, 1, 1, 0, 1, 16'h1111);
    add(0, 0, 16'h0000, 0, 1, 1, 0, 16'h0000);
    add(0, 1, 16'h5555, 0, 1, 1, 0, 16'h0000);
    add(0, 0, 16'h0000, 1, 1, 1, 1, 16'h5555);
    add(0, 0, 16'h0000, 0, 1, 1, 0, 16'h0000);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset_i = vecs[i].rst;
      v_i     = vecs[i].v;
      data_i  = vecs[i].d;
      yumi_i  = vecs[i].y;
      #1;
      if (vecs[i].chk) begin
        check($sformatf("vec%0d ready", i), 32'(ready_o), 32'(vecs[i].exp_ready));
        check($sformatf("vec%0d v", i), 32'(v_o), 32'(vecs[i].exp_v));
        if (vecs[i].exp_v)
          check($sformatf("vec%0d data", i), 32'(data_o), 32'(vecs[i].exp_data));
      end
    end

    // The directed sequence leaves the FIFO empty and out of reset.
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      logic pv, py;
      @(negedge clk);
      pv = ($urandom_range(0, 3) != 0);
      py = (q.size() > 0) && ($urandom_range(0, 2) != 0);
      reset_i = 1'b0;
      v_i     = pv;
      data_i  = W'($urandom);
      yumi_i  = py;
      #1;
      check("rand ready", 32'(ready_o), 32'(q.size() < 2));
      check("rand v", 32'(v_o), 32'(q.size() > 0));
      if (q.size() > 0) check("rand data", 32'(data_o), 32'(q[0]));
      if (py) void'(q.pop_front());
      if (pv && (q.size() + (py ? 1 : 0)) < 2) q.push_back(int'(data_i));
    end

    @(negedge clk);
    v_i = 1'b0;
    yumi_i = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
